// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
// Holds the writer FSM state type, the default framebuffer geometry and
// the helper that sizes the framebuffer address bus.
package fb_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } fb_state_t;

   localparam int FB_WIDTH_DEF  = 320;
   localparam int FB_HEIGHT_DEF = 180;

   // Address width needed to reach every pixel of a width x height buffer.
   function automatic int fb_addr_w(input int width, input int height);
      return $clog2(width * height);
   endfunction

endpackage

// File: rtl/fb_clip_addr.sv
// Two-stage clip and address pipeline for the framebuffer writer.
// S1 clips the signed coordinate and forms the row offset; S2 adds x and
// presents a write. The pipeline knows nothing about fills or the FSM: it
// only moves a valid bit along with the pixel.
module fb_clip_addr
   import fb_pkg::*;
#(
   parameter int CORDW     = 16,
   parameter int CIDXW     = 4,
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF,
   parameter int ADDRW     = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [CORDW-1:0] x,
   input  logic [CORDW-1:0] y,
   input  logic [CIDXW-1:0] cidx,
   output logic             s1_valid,
   output logic             s1_reject,
   output logic             out_valid,
   output logic [ADDRW-1:0] out_addr,
   output logic [CIDXW-1:0] out_din
);

   localparam logic signed [CORDW-1:0] X_LIM = CORDW'(FB_WIDTH);
   localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(FB_HEIGHT);
   localparam logic [ADDRW-1:0]        ROW_W = ADDRW'(FB_WIDTH);

   logic signed [CORDW-1:0] x_s;
   logic signed [CORDW-1:0] y_s;
   logic                    clip_ok;
   logic [ADDRW-1:0]        x_idx;
   logic [ADDRW-1:0]        y_idx;

   logic                    s1_ok;
   logic [ADDRW-1:0]        s1_row;
   logic [ADDRW-1:0]        s1_x;
   logic [CIDXW-1:0]        s1_cidx;

   assign x_s = $signed(x);
   assign y_s = $signed(y);

   // Clip test and in-range indices; out-of-range pixels feed zeros to the multiplier.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
      clip_ok = 1'b0;
      x_idx   = '0;
      y_idx   = '0;
      if (!x_s[CORDW-1] && !y_s[CORDW-1] && (x_s < X_LIM) && (y_s < Y_LIM)) begin
         clip_ok = 1'b1;
         x_idx   = ADDRW'($unsigned(x_s));
         y_idx   = ADDRW'($unsigned(y_s));
      end
   end

   // S1: register clip result, row offset, x and colour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use non-blocking assignments so every flop samples its inputs from before the edge.
         s1_valid <= 1'b0;
         s1_ok    <= 1'b0;
         s1_row   <= '0;
         s1_x     <= '0;
         s1_cidx  <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_ok    <= clip_ok;
         s1_row   <= y_idx * ROW_W;
         s1_x     <= x_idx;
         s1_cidx  <= cidx;
      end
   end

   // S2: final address and write strobe for in-range pixels only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_din   <= '0;
      end else begin
         out_valid <= s1_valid && s1_ok;
         out_addr  <= s1_row + s1_x;
         out_din   <= s1_cidx;
      end
   end

   assign s1_reject = s1_valid && !s1_ok;

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: clips the renderer's pixel stream and writes
// in-range pixels to a single-port framebuffer, one pixel per clock, and
// fills the whole buffer with a background colour on request. The renderer
// is stalled through oe while a fill drains the pipeline and runs.
// Optional feature macro: FBW_CLIP_COUNT_EN adds clip_cnt, a saturating
// count of accepted pixels rejected by the clip, cleared by reset and by
// an accepted clear.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int CORDW     = 16,
   parameter int CIDXW     = 4,
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF,
   parameter int ADDRW     = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CIDXW-1:0] bg_cidx,
   input  logic [CORDW-1:0] x,
   input  logic [CORDW-1:0] y,
   input  logic [CIDXW-1:0] cidx,
   input  logic             drawing,
   output logic             oe,
   output logic             fb_we,
   output logic [ADDRW-1:0] fb_addr,
   output logic [CIDXW-1:0] fb_din,
   output logic             busy,
   output logic             clear_done
`ifdef FBW_CLIP_COUNT_EN
   ,
   output logic [15:0]      clip_cnt
`endif
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

   fb_state_t        state;
   fb_state_t        state_n;
   logic             clear_acc;
   logic             fill_last;
   logic             drain_cnt;
   logic [ADDRW-1:0] fill_addr;
   logic [CIDXW-1:0] bg;

   logic             pix_accept;
   logic             s1_valid;
   logic             s1_reject;
   logic             pipe_we;
   logic [ADDRW-1:0] pipe_addr;
   logic [CIDXW-1:0] pipe_din;

   assign pix_accept = drawing && oe;

   fb_clip_addr #(
      .CORDW     (CORDW),
      .CIDXW     (CIDXW),
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT),
      .ADDRW     (ADDRW)
   ) u_clip_addr (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pix_accept),
      .x         (x),
      .y         (y),
      .cidx      (cidx),
      .s1_valid  (s1_valid),
      .s1_reject (s1_reject),
      .out_valid (pipe_we),
      .out_addr  (pipe_addr),
      .out_din   (pipe_din)
   );

   // Next-state logic: accept clear only in RUN, drain two cycles, then sweep the buffer.
   always_comb begin
      state_n   = state;
      clear_acc = 1'b0;
      fill_last = 1'b0;
      case (state)
         RUN: begin
            if (clear) begin
               clear_acc = 1'b1;
               state_n   = DRAIN;
            end
         end
         DRAIN: begin
            // Second drain cycle: S1 is empty and S2 holds the last pixel write.
            if (drain_cnt && !s1_valid) begin
               state_n = CLEAR;
            end
         end
         CLEAR: begin
            if (fill_addr == LAST_ADDR) begin
               fill_last = 1'b1;
               state_n   = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   // State register, renderer handshake, fill colour latch and fill address counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         oe         <= 1'b0;
         clear_done <= 1'b0;
         drain_cnt  <= 1'b0;
         fill_addr  <= '0;
         bg         <= '0;
      end else begin
         state      <= state_n;
         oe         <= (state_n == RUN);
         clear_done <= fill_last;
         drain_cnt  <= (state == DRAIN);
         if (clear_acc) begin
            bg <= bg_cidx;
         end
         if ((state == CLEAR) && !fill_last) begin
            fill_addr <= fill_addr + ADDRW'(1);
         end else begin
            fill_addr <= '0;
         end
      end
   end

   // Write-port mux: the fill owns the port in CLEAR, the pixel pipeline otherwise.
   always_comb begin
      fb_we   = pipe_we;
      fb_addr = pipe_addr;
      fb_din  = pipe_din;
      if (state == CLEAR) begin
         fb_we   = 1'b1;
         fb_addr = fill_addr;
         fb_din  = bg;
      end
   end

   assign busy = (state == DRAIN) || (state == CLEAR);

`ifdef FBW_CLIP_COUNT_EN
   // Saturating count of clipped pixels, restarted by each accepted clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clip_cnt <= '0;
      end else if (clear_acc) begin
         clip_cnt <= '0;
      end else if (s1_reject && (clip_cnt != 16'hFFFF)) begin
         clip_cnt <= clip_cnt + 16'd1;
      end
   end
`else
   logic unused_clip_reject;
   assign unused_clip_reject = s1_reject;
`endif

endmodule
